// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// One quotient bit per cycle; valid/ready on both sides; flush aborts an in-flight op.
module div_radix2 #(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_signed,
  input  logic         i_word,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_quot,
  output logic [N-1:0] o_rem
);

  localparam int H  = N / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_FULL = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [N-1:0]  MIN_FULL = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  MIN_HALF = {{(H+1){1'b1}}, {(H-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          word_q, neg_a_q, neg_q_q;
  logic [N-1:0]  b_mag_q, rem_q, quo_q;

  logic [N-1:0]  a_ext, b_ext, a_mag, b_mag, sp_quot, sp_rem;
  logic          neg_a, neg_b, special;
  logic [N:0]    rem_sh, diff;
  logic [N-1:0]  rem_nx, quo_nx, q_mag, q_fin, r_fin, res_quot, res_rem;
  logic          accept;

  function automatic logic [N-1:0] sext_w(input logic [N-1:0] v, input logic word);
    return word ? {{H{v[H-1]}}, v[H-1:0]} : v;
  endfunction

  assign accept = (state == IDLE) && i_valid && o_ready;

  // Operand preparation: extend W-variant operands, then divide magnitudes.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_ext = i_a;
    b_ext = i_b;
    if (i_word) begin
      a_ext = {{H{i_signed & i_a[H-1]}}, i_a[H-1:0]};
      b_ext = {{H{i_signed & i_b[H-1]}}, i_b[H-1:0]};
    end
    neg_a   = i_signed & a_ext[N-1];
    neg_b   = i_signed & b_ext[N-1];
    a_mag   = neg_a ? -a_ext : a_ext;
    b_mag   = neg_b ? -b_ext : b_ext;
    special = 1'b0;
    sp_quot = '0;
    sp_rem  = '0;
    if (b_ext == '0) begin
      special = 1'b1;
      sp_quot = '1;
      sp_rem  = sext_w(i_a, i_word);
    end else if (i_signed && b_ext == '1 && a_ext == (i_word ? MIN_HALF : MIN_FULL)) begin
      special = 1'b1;
      sp_quot = sext_w(i_a, i_word);
    end
  end

  // One restoring step; the final step also yields the signed, extended result.
  always_comb begin
    rem_sh   = {rem_q, quo_q[N-1]};
    diff     = rem_sh - {1'b0, b_mag_q};
    rem_nx   = diff[N] ? rem_sh[N-1:0] : diff[N-1:0];
    quo_nx   = {quo_q[N-2:0], ~diff[N]};
    q_mag    = word_q ? {{H{1'b0}}, quo_nx[H-1:0]} : quo_nx;
    q_fin    = neg_q_q ? -q_mag : q_mag;
    r_fin    = neg_a_q ? -rem_nx : rem_nx;
    res_quot = sext_w(q_fin, word_q);
    res_rem  = sext_w(r_fin, word_q);
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_quot  <= '0;
      o_rem   <= '0;
    end else if (i_flush) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          o_ready <= 1'b0;
          if (special) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_quot  <= sp_quot;
            o_rem   <= sp_rem;
          end else begin
            state <= CALC;
            cnt   <= i_word ? CNT_HALF : CNT_FULL;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_quot  <= res_quot;
            o_rem   <= res_rem;
          end
        end
        DONE: if (i_ready) begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      word_q  <= i_word;
      neg_a_q <= neg_a;
      neg_q_q <= neg_a ^ neg_b;
      b_mag_q <= b_mag;
      rem_q   <= '0;
      quo_q   <= i_word ? {a_mag[H-1:0], {H{1'b0}}} : a_mag;
    end else if (state == CALC) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed corner cases, backpressure, flush/reset,
// and randomized ops against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_div_radix2;

  logic        clk;
  logic        i_rst, i_flush, i_valid, i_signed, i_word, i_ready;
  logic [63:0] i_a, i_b;
  logic        o_ready, o_valid;
  logic [63:0] o_quot, o_rem;

  int vectors     = 0;
  int miscompares = 0;

  div_radix2 #(.N(64)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_signed(i_signed),
    .i_word  (i_word),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_quot  (o_quot),
    .o_rem   (o_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: RISC-V division semantics with ordinary integer arithmetic.
  function automatic void ref_div(input logic [63:0] a, b, input logic s, w,
                                  output logic [63:0] q, r, output int lat);
    logic [63:0] ae, be;
    longint sa, sb;
    ae  = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]}) : a;
    be  = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]}) : b;
    sa  = longint'(ae);
    sb  = longint'(be);
    lat = w ? 33 : 65;
    if (be == 64'd0) begin
      q = '1; r = ae; lat = 1;
    end else if (s && be == '1 && ae == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      q = ae; r = 64'd0; lat = 1;
    end else if (s) begin
      q = 64'(sa / sb); r = 64'(sa % sb);
    end else begin
      q = ae / be; r = ae % be;
    end
    if (w) begin
      q = {{32{q[31]}}, q[31:0]};
      r = {{32{r[31]}}, r[31:0]};
    end
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(15));
      4:       return {32'h0, $urandom()};
      5:       return 64'hFFFF_FFFF_8000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Drives one request from IDLE, records latency/result, stalls, then retires it.
  task automatic do_op(input logic [63:0] a, b, input logic s, w, input int stall,
                       input logic poke, output int lat, output logic [63:0] q, r,
                       output logic stable, output logic busy_ok);
    i_a = a; i_b = b; i_signed = s; i_word = w; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_a = {$urandom(), $urandom()}; i_b = {$urandom(), $urandom()};
    i_signed = 1'($urandom()); i_word = 1'($urandom());
    lat = -1; q = '0; r = '0; stable = 1'b1; busy_ok = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (o_ready !== 1'b0) busy_ok = 1'b0;
      if (o_valid === 1'b1) begin lat = c; break; end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      i_flush = 1'b1; @(posedge clk); #1; i_flush = 1'b0;
      return;
    end
    q = o_quot; r = o_rem;
    i_valid = poke;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b1 || o_quot !== q || o_rem !== r || o_ready !== 1'b0) stable = 1'b0;
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_signed = 1'b0; i_word = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_quot !== 64'd0 || o_rem !== 64'd0) begin
      miscompares++;
      $display("FAIL reset: ready=%b valid=%b quot=%h rem=%h, expected 1 0 0 0",
               o_ready, o_valid, o_quot, o_rem);
    end
  endtask

  task automatic test_directed_case(input string name, input logic [63:0] a, b,
                                    input logic s, w, input logic [63:0] eq, er, input int elat);
    int lat; logic [63:0] q, r; logic st, busy;
    do_op(a, b, s, w, 0, 1'b0, lat, q, r, st, busy);
    vectors += 4;
    if (lat !== elat) begin
      miscompares++; $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
    end
    if (q !== eq) begin
      miscompares++; $display("FAIL %s quot: got %h expected %h", name, q, eq);
    end
    if (r !== er) begin
      miscompares++; $display("FAIL %s rem: got %h expected %h", name, r, er);
    end
    if (!busy || o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s handshake: busy_ok=%b ready=%b valid=%b expected 1 1 0",
               name, busy, o_ready, o_valid);
    end
  endtask

  task automatic test_directed();
    test_directed_case("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
    test_directed_case("div_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, -64'sd3, -64'sd1, 65);
    test_directed_case("div_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, -64'sd3, 64'd1, 65);
    test_directed_case("divu_by_zero", 64'd5, 64'd0, 1'b0, 1'b0, '1, 64'd5, 1);
    test_directed_case("div_overflow", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0,
                       64'h8000_0000_0000_0000, 64'd0, 1);
    test_directed_case("divw_overflow", 64'h1234_5678_8000_0000, '1, 1'b1, 1'b1,
                       64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    test_directed_case("divuw_ffffffff_2", 64'h0000_0000_FFFF_FFFF, 64'd2, 1'b0, 1'b1,
                       64'h0000_0000_7FFF_FFFF, 64'd1, 33);
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] q, r; logic st, busy; int stray;
    do_op(64'd1000, 64'd33, 1'b0, 1'b0, 10, 1'b1, lat, q, r, st, busy);
    vectors += 3;
    if (!st) begin
      miscompares++; $display("FAIL backpressure stable: outputs changed while stalled");
    end
    if (q !== 64'd30 || r !== 64'd10) begin
      miscompares++; $display("FAIL backpressure result: got %h/%h expected 1e/a", q, r);
    end
    stray = 0;
    repeat (3) begin
      if (o_valid !== 1'b0 || o_ready !== 1'b1) stray++;
      @(posedge clk); #1;
    end
    if (stray != 0) begin
      miscompares++; $display("FAIL no_reaccept: %0d bad cycles, expected 0", stray);
    end
  endtask

  task automatic test_flush_reset();
    int lat, seen; logic [63:0] q, r; logic st, busy;
    i_a = 64'd100; i_b = 64'd7; i_signed = 1'b0; i_word = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (18) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    @(posedge clk); #1 i_flush = 1'b0;
    vectors += 2;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_idle: ready=%b valid=%b expected 1 0", o_ready, o_valid);
    end
    seen = 0;
    repeat (70) begin @(posedge clk); #1; if (o_valid !== 1'b0) seen++; end
    if (seen != 0) begin
      miscompares++; $display("FAIL flush_drop: o_valid high %0d cycles, expected 0", seen);
    end
    i_valid = 1'b1; i_flush = 1'b1; i_b = 64'd0;
    @(posedge clk); #1 i_valid = 1'b0; i_flush = 1'b0;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_with_valid: ready=%b valid=%b expected 1 0", o_ready, o_valid);
    end
    do_op(-64'sd100, 64'd9, 1'b1, 1'b0, 0, 1'b0, lat, q, r, st, busy);
    vectors++;
    if (q !== -64'sd11 || r !== -64'sd1 || lat !== 65) begin
      miscompares++; $display("FAIL after_flush: got %h/%h lat %0d expected -11/-1 lat 65", q, r, lat);
    end
    i_a = 64'd77; i_b = 64'd5; i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_quot !== 64'd0 || o_rem !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_mid_op: ready=%b valid=%b quot=%h rem=%h expected 1 0 0 0",
               o_ready, o_valid, o_quot, o_rem);
    end
  endtask

  task automatic test_random(input int n);
    logic [63:0] a, b, eq, er, q, r; logic s, w, st, busy; int elat, lat, k;
    for (int i = 0; i < n; i++) begin
      a = pick(); b = pick(); s = 1'($urandom()); w = 1'($urandom());
      ref_div(a, b, s, w, eq, er, elat);
      if ($urandom_range(15) == 0) begin
        i_a = a; i_b = b; i_signed = s; i_word = w; i_valid = 1'b1;
        @(posedge clk); #1 i_valid = 1'b0;
        k = $urandom_range(40);
        repeat (k) begin @(posedge clk); #1; end
        i_flush = 1'b1;
        @(posedge clk); #1 i_flush = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rand_flush[%0d]: valid=%b ready=%b expected 0 1", i, o_valid, o_ready);
        end
      end else begin
        do_op(a, b, s, w, $urandom_range(3), 1'b0, lat, q, r, st, busy);
        vectors += 3;
        if (q !== eq) begin
          miscompares++;
          $display("FAIL rand_quot[%0d] a=%h b=%h s=%b w=%b: got %h expected %h", i, a, b, s, w, q, eq);
        end
        if (r !== er) begin
          miscompares++;
          $display("FAIL rand_rem[%0d] a=%h b=%h s=%b w=%b: got %h expected %h", i, a, b, s, w, r, er);
        end
        if (lat !== elat || !st || !busy) begin
          miscompares++;
          $display("FAIL rand_timing[%0d]: lat %0d stable %b busy_ok %b expected lat %0d 1 1",
                   i, lat, st, busy, elat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush_reset();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
